// File: rtl/mantle_array_serializer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mantle_array_serializer_if
// Brief    : Array-in / word-out handshake bundle for the array serializer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface mantle_array_serializer_if #(
    parameter int WIDTH = 32,
    parameter int LEN   = 15
);
    localparam int IDXW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [WIDTH-1:0] in [LEN];
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [IDXW-1:0]  out_idx;

    // Array producer and word consumer, seen from outside the serializer.
    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_last, out_idx
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, out_last, out_idx
    );
endinterface
`default_nettype wire

// File: rtl/mantle_array_serializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mantle_array_serializer
// Brief    : Buffers a LEN-word array and streams it lowest index first.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mantle_array_serializer #(
    parameter int WIDTH = 32,
    parameter int LEN   = 15
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    mantle_array_serializer_if.slave   bus
);
    localparam int IDXW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(LEN - 1);
    localparam logic [IDXW-1:0] c_one      = IDXW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  w_idx_nxt;
    logic             w_load;
    logic [WIDTH-1:0] r_buf [LEN];

    logic w_send;
    logic w_last;
    logic w_acc;
    logic w_beat;

    assign w_send = rst_n && (r_state == ST_SEND);
    assign w_last = w_send && (r_idx == c_last_idx);
    assign w_acc  = bus.in_valid && bus.in_ready;
    assign w_beat = w_send && bus.out_ready;

    // Next array is taken during the last-word beat so frames abut.
    assign bus.in_ready  = rst_n && ((r_state == ST_IDLE) || (w_last && bus.out_ready));
    assign bus.out_valid = w_send;
    assign bus.out_last  = w_last;
    assign bus.out       = r_buf[r_idx];
    assign bus.out_idx   = r_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_beat) begin
                    if (r_idx != c_last_idx) begin
                        w_idx_nxt = r_idx + c_one;
                    end else if (w_acc) begin
                        w_idx_nxt = '0;
                        w_load    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            for (int i = 0; i < LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_load) begin
                r_buf <= bus.in;
            end
        end
    end
endmodule
`default_nettype wire
